fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end that replaces the free-running PC plus IF/ID register pair. It generates fetch addresses and talks to instruction memory over a req/ack handshake with variable latency. Fetched instructions go into a DEPTH-entry prefetch queue, which feeds decode through a valid/ready interface. Branch/jump redirects flush the queue and cancel or drop any in-flight fetch.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
mem_req  out  1  fetch request, held until mem_ack
mem_addr  out  XLEN  fetch address, stable while mem_req=1
mem_ack  in  1  mem_data valid this cycle; completes the request
mem_data  in  ILEN  fetched instruction
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new PC; bits [1:0] are ignored (forced 0)
id_valid  out  1  queue head valid
id_ready  in  1  decode accepts head this cycle
id_pc  out  XLEN  PC of head instruction
id_is  out  ILEN  head instruction
q_count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, mem_req=0, mem_addr=RESET_PC.
  - Queue empty, q_count=0, id_valid=0, id_pc=0, id_is=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; data is kept.
  - DROP: request outstanding; data is discarded.
  - mem_req = (state==WAIT || state==DROP). mem_req is registered; it never depends combinationally on mem_ack.
- Room check: room = (q_count - pop + outstanding_kept) < DEPTH. Overflow is therefore impossible.
- IDLE:
  - Room -> WAIT, with mem_addr=fetch_pc.
  - No room -> stay IDLE.
- WAIT with mem_ack:
  - Push {mem_addr, mem_data}; fetch_pc = mem_addr+4.
  - Room after push/pop -> WAIT with next address (back-to-back, 1 instr/cycle sustained).
  - Otherwise -> IDLE.
- WAIT without mem_ack: hold mem_addr and mem_req.
- DROP:
  - mem_ack -> discard data, then WAIT at fetch_pc.
  - No mem_ack -> hold.
- Redirect (highest priority; overrides push, pop and room):
  - Queue cleared next cycle; id_valid=0 next cycle. A same-cycle pop handshake is still consumed by decode but irrelevant.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - From IDLE, or from WAIT/DROP with mem_ack the same cycle: -> WAIT at the new PC, so mem_req with the new address appears at cycle N+1. Any acked data is discarded.
  - From WAIT/DROP without mem_ack: -> DROP. The old address is kept on mem_addr until ack, then the new PC is fetched.
  - Redirect while in DROP: only fetch_pc is updated.
- Latency:
  - mem_ack at cycle M -> id_valid=1 with that entry at M+1.
  - Redirect at N -> earliest id_valid at N+2, given an immediate ack.
- Queue:
  - FIFO order; head is exposed combinationally from storage.
  - Pop = id_valid && id_ready.
  - Simultaneous push and pop at any occupancy keeps q_count unchanged.
  - id_pc/id_is hold their value while id_valid && !id_ready.
- PC arithmetic is modulo 2^XLEN: 0xFFFFFFFC+4 wraps to 0x0.
- Reset asserted mid-request: state returns to IDLE immediately. Memory must tolerate an abandoned request.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, ILEN, INST_NOP (32'h00000013).
  - fetch state enum (IDLE/WAIT/DROP).
  - PC increment constant (4).
- One sub-module: fetch_fifo. Parameters are DEPTH and width XLEN+ILEN. Interface is push, pop, flush, head data, count, async active-low rst. Control FSM and PC logic stay in fetch_unit.

Test Plan:
- Reset: rst=0 for 3 cycles -> mem_req=0, id_valid=0, q_count=0. Release -> mem_req=1, mem_addr=0x0 on the next cycle.
- Streaming: mem_ack every cycle, id_ready=1, mem_data=0x00000013,0x00100093,... -> id_pc=0x0,0x4,0x8 on consecutive cycles, each pc with its matching id_is, one per cycle.
- Backpressure: DEPTH=4, id_ready=0, immediate ack -> exactly 4 pushes, then mem_req=0, q_count=4, id_pc=0x0 stable. Raise id_ready -> fetch resumes at 0x10, with no loss or duplication.
- Redirect during WAIT: ack delayed 3 cycles, redirect=1 with redirect_pc=0x102 -> mem_addr stays at the old PC until ack, and that data never appears. Next request mem_addr=0x100; first id_pc=0x100.
- Redirect coincident with ack and pop: q_count=2, redirect_pc=0x200 -> next cycle q_count=0, id_valid=0, mem_req=1, mem_addr=0x200.
- Wrap: RESET_PC=0xFFFFFFFC -> fetch addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and fetch-state encoding for the
//                instruction-fetch front end.
//                Contents: XLEN/ILEN defaults, canonical NOP encoding,
//                sequential PC increment, fetch FSM state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int PC_INCR = 4;

    // Fetch state encoding.
    //   IDLE : no request outstanding
    //   WAIT : request outstanding, returned data is queued
    //   DROP : request outstanding, returned data is discarded
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_WAIT = 2'd1;
    localparam fetch_state_t ST_DROP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Prefetch queue holding {pc, instruction} entries between
//                the fetch engine and decode. The head entry is driven
//                combinationally from storage; flush empties the queue
//                in one cycle and overrides push/pop.
//  Ports       : clk, rst (async, active-low)
//                push/wdata  - enqueue one entry
//                pop         - dequeue head entry
//                flush       - discard all entries
//                head        - oldest entry
//                count       - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is accepted only when the head leaves in
    // the same cycle; the fetch engine's room check normally prevents it.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Issues fetch addresses over a
//                req/ack memory handshake with variable latency, buffers
//                returned instructions in a DEPTH-entry prefetch queue and
//                presents them to decode through valid/ready. A redirect
//                flushes the queue and either restarts fetch at once or
//                drops the in-flight response first.
//  Ports       : clk, rst (async, active-low)
//                mem_req/mem_addr/mem_ack/mem_data - instruction memory
//                redirect/redirect_pc               - control-flow restart
//                id_valid/id_ready/id_pc/id_is      - decode interface
//                q_count                            - queue occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              ILEN     = riscv_pkg::ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_req,
    output logic [XLEN-1:0]            mem_addr,
    input  logic                       mem_ack,
    input  logic [ILEN-1:0]            mem_data,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [ILEN-1:0]            id_is,
    output logic [$clog2(DEPTH):0]     q_count
);

    import riscv_pkg::*;

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_nx;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  fetch_pc_nx;
    logic [XLEN-1:0]  mem_addr_nx;
    logic [XLEN-1:0]  addr_inc;
    logic [XLEN-1:0]  redirect_base;
    logic [CW:0]      occ;
    logic             pop;
    logic             push;
    logic             room;

    assign pop           = id_valid && id_ready;
    assign push          = (state == ST_WAIT) && mem_ack && !redirect;
    assign addr_inc      = mem_addr + XLEN'(PC_INCR);
    assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

    // Occupancy as it will be once the kept outstanding request (if any)
    // lands and this cycle's pop retires. A new request is issued only if
    // that leaves a free slot, so the queue can never overflow.
    assign occ  = {1'b0, q_count} - (CW+1)'(pop) + (CW+1)'(state == ST_WAIT);
    assign room = (occ < DEPTH_C);

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        mem_addr_nx = mem_addr;
        if (redirect) begin
            fetch_pc_nx = redirect_base;
            // The old request must complete before a new address may be
            // presented; if it is still pending, its data is dropped.
            if ((state == ST_IDLE) || mem_ack) begin
                state_nx    = ST_WAIT;
                mem_addr_nx = redirect_base;
            end else begin
                state_nx    = ST_DROP;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (room) begin
                        state_nx    = ST_WAIT;
                        mem_addr_nx = fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        fetch_pc_nx = addr_inc;
                        if (room) begin
                            mem_addr_nx = addr_inc;
                        end else begin
                            state_nx    = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    // Queue was flushed on entry to DROP, so room exists.
                    if (mem_ack) begin
                        state_nx    = ST_WAIT;
                        mem_addr_nx = fetch_pc;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nx;
            mem_req  <= (state_nx == ST_WAIT) || (state_nx == ST_DROP);
            mem_addr <= mem_addr_nx;
            fetch_pc <= fetch_pc_nx;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({mem_addr, mem_data}),
        .head  ({id_pc, id_is}),
        .count (q_count)
    );

    assign id_valid = (q_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. A scoreboard
//                queue receives {pc, instruction} whenever the bench acks a
//                request whose data must be kept; every decode handshake
//                pops and compares. A second instance with a wrapping
//                RESET_PC and an always-acking memory checks PC wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_is;
    logic [2:0]  q_count;

    // Wrap instance signals
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_data;
    logic        w_redirect = 1'b0;
    logic [31:0] w_rpc      = 32'h0;
    logic        w_valid;
    logic        w_ready    = 1'b1;
    logic [31:0] w_pc;
    logic [31:0] w_is;
    logic [2:0]  w_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] is;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   drop_pending = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_is(id_is), .q_count(q_count)
    );

    fetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)
    ) dut_wrap (
        .clk(clk), .rst(rst),
        .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_ack), .mem_data(w_data),
        .redirect(w_redirect), .redirect_pc(w_rpc),
        .id_valid(w_valid), .id_ready(w_ready),
        .id_pc(w_pc), .id_is(w_is), .q_count(w_count)
    );

    // addi xK, x0, K pattern keyed on the word address
    function automatic logic [31:0] inst_for(input logic [31:0] a);
        logic [11:0] k;
        k = a[13:2];
        return {k, 5'd0, 3'd0, k[4:0], 7'h13};
    endfunction

    assign w_ack  = w_req;
    assign w_data = inst_for(w_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, applied at the falling edge.
    task automatic step(input bit ack, input bit redir, input logic [31:0] rpc);
        exp_t e;
        mem_ack     = ack && mem_req;
        mem_data    = inst_for(mem_addr);
        redirect    = redir;
        redirect_pc = rpc;
        if (id_valid && id_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(id_pc), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("id_pc", 64'(id_pc), 64'(e.pc));
                chk("id_is", 64'(id_is), 64'(e.is));
            end
        end
        if (redir) sb.delete();
        if (mem_ack) begin
            if (!redir && !drop_pending) begin
                e.pc = mem_addr;
                e.is = inst_for(mem_addr);
                sb.push_back(e);
            end
            drop_pending = 1'b0;
        end
        if (redir && mem_req && !mem_ack) drop_pending = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack  = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        mem_ack  = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        drop_pending = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;

        // ---------------- Reset ----------------
        repeat (3) @(negedge clk);
        chk("rst_mem_req",  64'(mem_req),  64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_q_count",  64'(q_count),  64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_id_pc",    64'(id_pc),    64'd0);
        chk("rst_id_is",    64'(id_is),    64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_mem_req",  64'(mem_req),  64'd1);
        chk("rel_mem_addr", 64'(mem_addr), 64'd0);

        // ---------------- Streaming ----------------
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_addr", 64'(mem_addr), 64'(32'(i * 4)));
            if (i > 0) begin
                chk("stream_valid", 64'(id_valid), 64'd1);
                chk("stream_pc",    64'(id_pc),    64'(32'((i - 1) * 4)));
            end
            step(1'b1, 1'b0, 32'h0);
        end

        // ---------------- Backpressure ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("bp_addr", 64'(mem_addr), 64'(32'(i * 4)));
            step(1'b1, 1'b0, 32'h0);
        end
        chk("bp_req_off", 64'(mem_req), 64'd0);
        chk("bp_count",   64'(q_count), 64'd4);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("bp_hold_req", 64'(mem_req), 64'd0);
            chk("bp_hold_pc",  64'(id_pc),   64'd0);
            chk("bp_hold_cnt", 64'(q_count), 64'd4);
        end
        id_ready = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        chk("bp_resume_req",  64'(mem_req),  64'd1);
        chk("bp_resume_addr", 64'(mem_addr), 64'h10);
        chk("bp_resume_cnt",  64'(q_count),  64'd3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        chk("bp_drained",  64'(id_valid),  64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // ---------------- Redirect during WAIT ----------------
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        chk("rw_count1", 64'(q_count),  64'd1);
        chk("rw_addr4",  64'(mem_addr), 64'h4);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h102);
        chk("rw_flush_cnt", 64'(q_count),  64'd0);
        chk("rw_flush_vld", 64'(id_valid), 64'd0);
        chk("rw_drop_req",  64'(mem_req),  64'd1);
        chk("rw_drop_addr", 64'(mem_addr), 64'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("rw_drop_hold", 64'(mem_addr), 64'h4);
        step(1'b1, 1'b0, 32'h0);
        chk("rw_new_addr",  64'(mem_addr), 64'h100);
        chk("rw_discarded", 64'(q_count),  64'd0);
        id_ready = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        chk("rw_first_vld", 64'(id_valid), 64'd1);
        chk("rw_first_pc",  64'(id_pc),    64'h100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // ---------------- Redirect with ack and pop ----------------
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("rc_count2", 64'(q_count), 64'd2);
        id_ready = 1'b1;
        step(1'b1, 1'b1, 32'h200);
        chk("rc_count0", 64'(q_count),  64'd0);
        chk("rc_vld0",   64'(id_valid), 64'd0);
        chk("rc_req",    64'(mem_req),  64'd1);
        chk("rc_addr",   64'(mem_addr), 64'h200);
        step(1'b1, 1'b0, 32'h0);
        chk("rc_vld1", 64'(id_valid), 64'd1);
        chk("rc_pc",   64'(id_pc),    64'h200);
        step(1'b1, 1'b0, 32'h0);

        // ---------------- PC wrap ----------------
        do_reset();
        chk("wrap_addr0", 64'(w_addr), 64'hFFFF_FFFC);
        chk("wrap_req",   64'(w_req),  64'd1);
        @(negedge clk);
        chk("wrap_addr1", 64'(w_addr), 64'h0);
        chk("wrap_pc0",   64'(w_pc),   64'hFFFF_FFFC);
        chk("wrap_is0",   64'(w_is),   64'(inst_for(32'hFFFF_FFFC)));
        @(negedge clk);
        chk("wrap_pc1",   64'(w_pc),   64'h0);
        chk("wrap_is1",   64'(w_is),   64'(inst_for(32'h0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
